// File: rtl/io_handshake_port.sv
// io_handshake_port: buffered processor I/O port.
// The device side speaks a 4-phase request/acknowledge protocol in each direction.
// The processor side sees a first-word-fall-through RX FIFO, a TX FIFO, occupancy
// counts and sticky error flags. Loopback mode moves RX entries straight into TX.
module io_handshake_port #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    // device -> port (inbound 4-phase)
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_data_ready_i,
    output logic             in_ack_o,
    // port -> device (outbound 4-phase)
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_data_ready_o,
    input  logic             out_ack_i,
    // processor RX side
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rx_empty_o,
    output logic [AW:0]      rx_count_o,
    // processor TX side
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             tx_full_o,
    output logic [AW:0]      tx_count_o,
    // mode and status
    input  logic             loopback_i,
    input  logic             clr_err_i,
    output logic             rx_underflow_o,
    output logic             tx_overflow_o
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_C  = {(AW + 1){1'b0}};
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_WAIT = 2'd2
    } tx_state_t;

    // storage and state
    logic [WIDTH-1:0] rx_mem_q [DEPTH];
    logic [WIDTH-1:0] tx_mem_q [DEPTH];
    logic [AW-1:0]    rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
    logic [AW:0]      rx_count_q, rx_count_d;
    logic [AW:0]      tx_count_q, tx_count_d;
    rx_state_t        rx_state_q;
    tx_state_t        tx_state_q;
    logic             in_ack_q;
    logic             out_rdy_q;
    logic [WIDTH-1:0] out_data_q;
    logic             rx_uf_q, rx_uf_d;
    logic             tx_of_q, tx_of_d;

    // derived control
    logic             rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic             rx_push_s, rx_pop_s, tx_push_s, tx_pop_s, move_s;
    logic             rx_uf_set_s, tx_of_set_s;
    logic [WIDTH-1:0] rx_head_s, tx_head_s, tx_push_data_s;

    // Status decode, push/pop arbitration and error detection.
    always_comb begin
        rx_empty_s = (rx_count_q == ZERO_C);
        rx_full_s  = (rx_count_q == DEPTH_C);
        tx_empty_s = (tx_count_q == ZERO_C);
        tx_full_s  = (tx_count_q == DEPTH_C);
        rx_head_s  = rx_mem_q[rx_rptr_q];
        tx_head_s  = tx_mem_q[tx_rptr_q];
        // Inbound push only from an idle handshake with room before this cycle.
        rx_push_s  = (rx_state_q == R_IDLE) && in_data_ready_i && !rx_full_s;
        tx_pop_s   = (tx_state_q == T_IDLE) && !tx_empty_s;
        move_s     = loopback_i && !rx_empty_s && !tx_full_s;
        if (loopback_i) begin
            // Processor strobes are ignored entirely in loopback.
            rx_pop_s       = move_s;
            tx_push_s      = move_s;
            tx_push_data_s = rx_head_s;
            rx_uf_set_s    = 1'b0;
            tx_of_set_s    = 1'b0;
        end else begin
            rx_pop_s       = rd_en_i && !rx_empty_s;
            // A write into a full TX is dropped even if the TX FSM pops this cycle.
            tx_push_s      = wr_en_i && !tx_full_s;
            tx_push_data_s = wr_data_i;
            rx_uf_set_s    = rd_en_i && rx_empty_s;
            tx_of_set_s    = wr_en_i && tx_full_s;
        end
    end

    // Next occupancy counts and sticky flags (a new error beats clr_err).
    always_comb begin
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_d = rx_count_q + ONE_C;
            2'b01:   rx_count_d = rx_count_q - ONE_C;
            default: rx_count_d = rx_count_q;
        endcase
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + ONE_C;
            2'b01:   tx_count_d = tx_count_q - ONE_C;
            default: tx_count_d = tx_count_q;
        endcase
        if (rx_uf_set_s) begin
            rx_uf_d = 1'b1;
        end else if (clr_err_i) begin
            rx_uf_d = 1'b0;
        end else begin
            rx_uf_d = rx_uf_q;
        end
        if (tx_of_set_s) begin
            tx_of_d = 1'b1;
        end else if (clr_err_i) begin
            tx_of_d = 1'b0;
        end else begin
            tx_of_d = tx_of_q;
        end
    end

    // FIFO storage, pointers, counts and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_q[i] <= {WIDTH{1'b0}};
                tx_mem_q[i] <= {WIDTH{1'b0}};
            end
            rx_wptr_q  <= {AW{1'b0}};
            rx_rptr_q  <= {AW{1'b0}};
            tx_wptr_q  <= {AW{1'b0}};
            tx_rptr_q  <= {AW{1'b0}};
            rx_count_q <= ZERO_C;
            tx_count_q <= ZERO_C;
            rx_uf_q    <= 1'b0;
            tx_of_q    <= 1'b0;
        end else begin
            if (rx_push_s) begin
                rx_mem_q[rx_wptr_q] <= in_data_i;
                rx_wptr_q           <= rx_wptr_q + PTR_ONE_C;
            end
            if (rx_pop_s) begin
                rx_rptr_q <= rx_rptr_q + PTR_ONE_C;
            end
            if (tx_push_s) begin
                tx_mem_q[tx_wptr_q] <= tx_push_data_s;
                tx_wptr_q           <= tx_wptr_q + PTR_ONE_C;
            end
            if (tx_pop_s) begin
                tx_rptr_q <= tx_rptr_q + PTR_ONE_C;
            end
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
            rx_uf_q    <= rx_uf_d;
            tx_of_q    <= tx_of_d;
        end
    end

    // Inbound handshake FSM: acknowledge once per request, hold until request drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= R_IDLE;
            in_ack_q   <= 1'b0;
        end else begin
            case (rx_state_q)
                R_IDLE: begin
                    if (rx_push_s) begin
                        in_ack_q   <= 1'b1;
                        rx_state_q <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!in_data_ready_i) begin
                        in_ack_q   <= 1'b0;
                        rx_state_q <= R_IDLE;
                    end
                end
                default: begin
                    in_ack_q   <= 1'b0;
                    rx_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Outbound handshake FSM: load head, request, wait for full ACK cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            out_rdy_q  <= 1'b0;
            out_data_q <= {WIDTH{1'b0}};
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (tx_pop_s) begin
                        out_data_q <= tx_head_s;
                        out_rdy_q  <= 1'b1;
                        tx_state_q <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (out_ack_i) begin
                        out_rdy_q  <= 1'b0;
                        tx_state_q <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (!out_ack_i) begin
                        tx_state_q <= T_IDLE;
                    end
                end
                default: begin
                    out_rdy_q  <= 1'b0;
                    tx_state_q <= T_IDLE;
                end
            endcase
        end
    end

    assign in_ack_o         = in_ack_q;
    assign out_data_o       = out_data_q;
    assign out_data_ready_o = out_rdy_q;
    assign rd_data_o        = rx_head_s;
    assign rx_empty_o       = rx_empty_s;
    assign rx_count_o       = rx_count_q;
    assign tx_full_o        = tx_full_s;
    assign tx_count_o       = tx_count_q;
    assign rx_underflow_o   = rx_uf_q;
    assign tx_overflow_o    = tx_of_q;

endmodule
